// File: rtl/fix_ari_acc_if.sv
// Handshake bundle for fix_ari_acc: product beats in, saturated Q7.8 result out.
// Optional macro FIX_ACC_BIAS_EN adds the bias_in signal to the bundle.
interface fix_ari_acc_if #(
    parameter int DATA = 16,
    parameter int LENW = 9
);
    logic            in_valid;
    logic            in_ready;
    logic [DATA-1:0] in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [DATA-1:0] out_data;
    logic [LENW-1:0] out_len;
    logic            out_ovf;
`ifdef FIX_ACC_BIAS_EN
    logic [DATA-1:0] bias_in;

    modport master (
        output in_valid, in_data, in_last, out_ready, bias_in,
        input  in_ready, out_valid, out_data, out_len, out_ovf
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready, bias_in,
        output in_ready, out_valid, out_data, out_len, out_ovf
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_len, out_ovf
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_len, out_ovf
    );
`endif
endinterface

// File: rtl/fix_ari_acc.sv
// fix_ari_acc: sums a packet of Q7.8 products in a saturating ACCW-bit accumulator and
// returns the result clipped to Q7.8 through a valid/ready output register.
// Optional macro FIX_ACC_BIAS_EN: adds bias_in, sampled on the closing beat and added
// (with ACCW saturation) before the output clip.
module fix_ari_acc #(
    parameter int DATA   = 16,
    parameter int POIN   = 8,
    parameter int ACCW   = 24,
    parameter int MAXLEN = 256,
    parameter int LENW   = $clog2(MAXLEN + 1)
) (
    input  logic         clk,
    input  logic         rst,
    fix_ari_acc_if.slave bus
);
    typedef enum logic {S_ACC, S_OUT} state_t;

    localparam logic [LENW-1:0] LAST_CNT = LENW'(MAXLEN - 1);
    localparam logic [ACCW-1:0] ACC_MAX  = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic [ACCW-1:0] ACC_MIN  = {1'b1, {(ACCW-1){1'b0}}};
    localparam logic [DATA-1:0] OUT_MAX  = {1'b0, {(DATA-1){1'b1}}};
    localparam logic [DATA-1:0] OUT_MIN  = {1'b1, {(DATA-1){1'b0}}};

    // Q7.8 in and out with no rescaling; the fraction width only has to fit the word.
    if (ACCW <= DATA || POIN >= DATA) begin : g_param_check
        $error("fix_ari_acc: need ACCW > DATA and POIN < DATA");
    end

    state_t          state, state_n;
    logic            in_ready, out_valid, beat, close;
    logic [ACCW-1:0] acc, acc_n, acc_b;
    logic [ACCW:0]   sum_w, bias_w;
    logic            sat_acc, sat_bias, clip;
    logic [DATA-1:0] bias, res_data;
    logic [LENW-1:0] cnt;
    logic            ovf_sticky;
    logic [DATA-1:0] out_data;
    logic [LENW-1:0] out_len;
    logic            out_ovf;

`ifdef FIX_ACC_BIAS_EN
    assign bias = bus.bias_in;
`else
    assign bias = '0;
`endif

    assign beat          = bus.in_valid & in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_len   = out_len;
    assign bus.out_ovf   = out_ovf;

    // State register: accumulate packet beats, then hold the result until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ACC;
        end else begin
            state <= state_n;
        end
    end

    // Next state and handshake outputs; a closing beat moves to S_OUT, acceptance returns.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_ACC: begin
                in_ready = ~rst;
                if (bus.in_valid && !rst && (bus.in_last || cnt == LAST_CNT)) begin
                    state_n = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_n = S_ACC;
                end
            end
            default: state_n = S_ACC;
        endcase
    end

    // Saturating add of this beat, optional bias add, and the final Q7.8 clip.
    always_comb begin
        sum_w    = {acc[ACCW-1], acc} + {{(ACCW+1-DATA){bus.in_data[DATA-1]}}, bus.in_data};
        sat_acc  = sum_w[ACCW] ^ sum_w[ACCW-1];
        acc_n    = sat_acc ? (sum_w[ACCW] ? ACC_MIN : ACC_MAX) : sum_w[ACCW-1:0];

        bias_w   = {acc_n[ACCW-1], acc_n} + {{(ACCW+1-DATA){bias[DATA-1]}}, bias};
        sat_bias = bias_w[ACCW] ^ bias_w[ACCW-1];
        acc_b    = sat_bias ? (bias_w[ACCW] ? ACC_MIN : ACC_MAX) : bias_w[ACCW-1:0];

        // In range only when every bit above the Q7.8 sign bit copies it.
        clip     = ~((&acc_b[ACCW-1:DATA-1]) | ~(|acc_b[ACCW-1:DATA-1]));
        res_data = clip ? (acc_b[ACCW-1] ? OUT_MIN : OUT_MAX) : acc_b[DATA-1:0];

        close    = bus.in_last | (cnt == LAST_CNT);
    end

    // Accumulator, beat counter, sticky overflow and the held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            out_data   <= '0;
            out_len    <= '0;
            out_ovf    <= 1'b0;
        end else if (beat) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (close) begin
                acc        <= '0;
                cnt        <= '0;
                ovf_sticky <= 1'b0;
                out_data   <= res_data;
                out_len    <= cnt + 1'b1;
                out_ovf    <= ovf_sticky | sat_acc | sat_bias | clip;
            end else begin
                acc        <= acc_n;
                cnt        <= cnt + 1'b1;
                ovf_sticky <= ovf_sticky | sat_acc;
            end
        end
    end
endmodule

// File: tb/tb_fix_ari_acc.sv
// Self-checking bench for fix_ari_acc: directed packets, a plain-arithmetic packet model
// compared every cycle, and literal expectations for each directed packet.
// Builds with or without FIX_ACC_BIAS_EN.
module tb_fix_ari_acc;
    localparam int     DATA    = 16;
    localparam int     LENW    = 9;
    localparam int     MAXLEN  = 256;
    localparam longint ACC_MAX = 64'sd8388607;
    localparam longint ACC_MIN = -64'sd8388608;

    typedef struct {
        logic [15:0] d;
        int          len;
        bit          ovf;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fix_ari_acc_if #(.DATA(DATA), .LENW(LENW)) bus ();

    fix_ari_acc #(.DATA(DATA), .ACCW(24), .MAXLEN(MAXLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- packet model ----------------
    longint      m_sum = 0;
    int          m_cnt = 0;
    bit          m_ovf = 0;
    bit          m_pend = 0;
    bit          armed = 0;
    logic [15:0] e_data = '0;
    int          e_len = 0;
    bit          e_ovf = 0;
    int          taken = 0;

    always @(posedge clk) begin : model
        longint tot;
        longint bias_v;
        bit     o;
        if (rst) begin
            m_sum = 0; m_cnt = 0; m_ovf = 0; m_pend = 0; armed = 1;
        end else if (armed) begin
            if (m_pend) begin
                if (bus.out_ready) m_pend = 0;
            end else if (bus.in_valid) begin
                taken++;
                m_sum = m_sum + longint'($signed(bus.in_data));
                if (m_sum > ACC_MAX) begin m_sum = ACC_MAX; m_ovf = 1; end
                if (m_sum < ACC_MIN) begin m_sum = ACC_MIN; m_ovf = 1; end
                m_cnt++;
                if (bus.in_last || m_cnt == MAXLEN) begin
`ifdef FIX_ACC_BIAS_EN
                    bias_v = longint'($signed(bus.bias_in));
`else
                    bias_v = 0;
`endif
                    o   = m_ovf;
                    tot = m_sum + bias_v;
                    if (tot > ACC_MAX) begin tot = ACC_MAX; o = 1; end
                    if (tot < ACC_MIN) begin tot = ACC_MIN; o = 1; end
                    if (tot > 32767) begin
                        e_data = 16'h7FFF; o = 1;
                    end else if (tot < -32768) begin
                        e_data = 16'h8000; o = 1;
                    end else begin
                        e_data = tot[15:0];
                    end
                    e_len = m_cnt;
                    e_ovf = o;
                    m_pend = 1;
                    m_sum = 0; m_cnt = 0; m_ovf = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    result_t r_q[$];

    always @(negedge clk) begin
        if (armed) begin
            check("in_ready", longint'(bus.in_ready), longint'(!rst && !m_pend));
            check("out_valid", longint'(bus.out_valid), longint'(m_pend));
            if (m_pend) begin
                check("out_data", longint'(bus.out_data), longint'(e_data));
                check("out_len", longint'(bus.out_len), longint'(e_len));
                check("out_ovf", longint'(bus.out_ovf), longint'(e_ovf));
            end
            if (bus.out_valid && bus.out_ready) begin
                r_q.push_back('{d: bus.out_data, len: int'(bus.out_len), ovf: bus.out_ovf});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] data, input logic last);
        int t0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        t0 = taken;
        for (int k = 0; k < 2000 && taken == t0; k++) step();
        if (taken == t0) check("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [15:0] d, input int len,
                                 input bit ovf);
        result_t r;
        for (int k = 0; k < 2000 && r_q.size() == 0; k++) step();
        if (r_q.size() == 0) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            r = r_q.pop_front();
            check({name, "_data"}, longint'(r.d), longint'(d));
            check({name, "_len"}, longint'(r.len), longint'(len));
            check({name, "_ovf"}, longint'(r.ovf), longint'(ovf));
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int t0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
`ifdef FIX_ACC_BIAS_EN
        bus.bias_in   = '0;
`endif
        rst = 1'b1;
        step();
        step();
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_data", longint'(bus.out_data), 0);
        check("rst_out_len", longint'(bus.out_len), 0);
        check("rst_out_ovf", longint'(bus.out_ovf), 0);
        check("rst_in_ready", longint'(bus.in_ready), 0);
        rst = 1'b0;
        step();

        // 1: 1.0 + 2.0 - 1.0 = 2.0
        send(16'h0100, 1'b0);
        send(16'h0200, 1'b0);
        send(16'hFF00, 1'b1);
        expect_result("t1", 16'h0200, 3, 1'b0);

        // 2: 200 * 0x7FFF fits the accumulator but clips the output
        for (int i = 0; i < 200; i++) send(16'h7FFF, (i == 199));
        expect_result("t2", 16'h7FFF, 200, 1'b1);

        // sticky overflow must not leak into the next packet
        send(16'hFF80, 1'b0);
        send(16'hFF80, 1'b1);
        expect_result("neg", 16'hFF00, 2, 1'b0);

        // negative clip
        for (int i = 0; i < 3; i++) send(16'h8000, (i == 2));
        expect_result("negclip", 16'h8000, 3, 1'b1);

        // 3: back-pressure with the next beat already waiting
        bus.out_ready = 1'b0;
        send(16'h0080, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0100;
        bus.in_last  = 1'b1;
        t0 = taken;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_stall_ready", longint'(bus.in_ready), 0);
            check("t3_stall_valid", longint'(bus.out_valid), 1);
            check("t3_stall_data", longint'(bus.out_data), 16'h0080);
            check("t3_stall_taken", longint'(taken), longint'(t0));
        end
        bus.out_ready = 1'b1;
        step();
        check("t3_bubble_taken", longint'(taken), longint'(t0));
        check("t3_bubble_ready", longint'(bus.in_ready), 1);
        step();
        check("t3_after_taken", longint'(taken), longint'(t0 + 1));
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        expect_result("t3a", 16'h0080, 1, 1'b0);
        expect_result("t3b", 16'h0100, 1, 1'b0);

        // 4: forced close at MAXLEN
        for (int i = 0; i < MAXLEN; i++) send(16'h0001, 1'b0);
        expect_result("t4", 16'h0100, 256, 1'b0);

        // 5: reset mid-packet discards the partial sum
        send(16'h0100, 1'b0);
        send(16'h0100, 1'b0);
        rst = 1'b1;
        step();
        check("t5_rst_valid", longint'(bus.out_valid), 0);
        check("t5_rst_data", longint'(bus.out_data), 0);
        check("t5_rst_len", longint'(bus.out_len), 0);
        check("t5_rst_ready", longint'(bus.in_ready), 0);
        rst = 1'b0;
        send(16'h0080, 1'b1);
        expect_result("t5", 16'h0080, 1, 1'b0);

        // 6: bias
`ifdef FIX_ACC_BIAS_EN
        bus.bias_in = 16'h0100;
        send(16'h0100, 1'b1);
        expect_result("t6", 16'h0200, 1, 1'b0);
        bus.bias_in = '0;
`else
        send(16'h0100, 1'b1);
        expect_result("t6", 16'h0100, 1, 1'b0);
`endif

        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
